// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed/unsigned multiply, multiply-accumulate and restoring divide unit with flush.
module multdiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             flush,
  output logic             busy,
  output logic             ok,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + MUL_LAT + 2);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hin_q, hin_d, lin_q, lin_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic busy_q, busy_d, ok_q, ok_d;
  logic idle, m_sgn, d_sgn, ge;
  logic [2:0] m_op;
  logic [WIDTH-1:0] m_a, m_b, abs_a, abs_b, nrem, nquo, q_fin, r_fin;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mres;
  logic [WIDTH:0] r_sh, diff;
  always_comb begin
    idle  = st_q == IDLE;
    // in IDLE the multiplier works straight from the ports so MUL_LAT==1 can finish on the accept edge
    m_op  = idle ? op : op_q;
    m_a   = idle ? a : a_q;
    m_b   = idle ? b : b_q;
    m_sgn = ~m_op[0];
    ext_a = {{WIDTH{m_sgn & m_a[WIDTH-1]}}, m_a};
    ext_b = {{WIDTH{m_sgn & m_b[WIDTH-1]}}, m_b};
    prod  = ext_a * ext_b;
    acc   = idle ? {hi_in, lo_in} : {hin_q, lin_q};
    mres  = ~m_op[2] ? prod : m_op[1] ? acc - prod : acc + prod;
    d_sgn = ~op_q[0];
    abs_a = d_sgn & a_q[WIDTH-1] ? -a_q : a_q;
    abs_b = d_sgn & b_q[WIDTH-1] ? -b_q : b_q;
    r_sh  = {rem_q, quo_q[WIDTH-1]};
    diff  = r_sh - {1'b0, dvs_q};
    ge    = ~diff[WIDTH];
    nrem  = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    nquo  = {quo_q[WIDTH-2:0], ge};
    q_fin = b_q == '0 ? '1 : d_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -nquo : nquo;
    r_fin = b_q == '0 ? a_q : d_sgn & a_q[WIDTH-1] ? -nrem : nrem;
    st_d  = st_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hin_d = hin_q;
    lin_d = lin_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    ok_d  = 1'b0;
    if (flush) st_d = IDLE;
    else case (st_q)
      IDLE: if (start) begin
        op_d  = op;
        a_d   = a;
        b_d   = b;
        hin_d = hi_in;
        lin_d = lo_in;
        cnt_d = CW'(1);
        if (op[2:1] == 2'b01) st_d = DIV;
        else if (MUL_LAT == 1) begin
          ok_d = 1'b1;
          {hi_d, lo_d} = mres;
        end else st_d = MUL;
      end
      MUL: if (cnt_q == CW'(MUL_LAT - 1)) begin
        st_d = IDLE;
        ok_d = 1'b1;
        {hi_d, lo_d} = mres;
      end else cnt_d = cnt_q + 1'b1;
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) begin
          rem_d = '0;
          quo_d = abs_a;
          dvs_d = abs_b;
        end else if (cnt_q == CW'(WIDTH + 1)) begin
          st_d = IDLE;
          ok_d = 1'b1;
          hi_d = r_fin;
          lo_d = q_fin;
        end else begin
          rem_d = nrem;
          quo_d = nquo;
        end
      end
      default: st_d = IDLE;
    endcase
    busy_d = st_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hin_q  <= '0;
      lin_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hin_q  <= hin_d;
      lin_q  <= lin_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      ok_q   <= ok_d;
    end
  end
  assign busy = busy_q;
  assign ok   = ok_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: random and directed checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;
  localparam int W = 32, ML = 3;
  logic clk = 1'b0;
  logic reset, start, flush, busy, ok;
  logic [2:0] op, r_op;
  logic [W-1:0] a, b, hi_in, lo_in, hi, lo;
  logic [63:0] last_res;
  int n_chk = 0, n_err = 0;

  multdiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush), .busy(busy), .ok(ok), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
    logic [63:0] p;
    int q, r;
    if (o[0]) p = {32'b0, x} * {32'b0, y};
    else p = longint'($signed(x)) * longint'($signed(y));
    case (o)
      3'd0, 3'd1: return p;
      3'd4, 3'd5: return {h, l} + p;
      3'd6, 3'd7: return {h, l} - p;
      3'd3: return y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, x};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ok(input string tag, input int n0, input int lat, input logic [63:0] exp);
    int n;
    n = n0;
    while (!ok && n < lat + 20) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy_at_ok"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    last_res = exp;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, y, h, l, input bit noise, input string tag);
    int n0;
    @(negedge clk);
    check({tag, " ok_low"}, 64'(ok), 64'd0);
    start = 1'b1; op = o; a = x; b = y; hi_in = h; lo_in = l;
    @(posedge clk);
    @(negedge clk);
    start = noise;
    n0 = 1;
    if (noise) begin
      op = 3'($urandom); a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
      check({tag, " busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b0;
      n0 = 2;
    end
    wait_ok(tag, n0, (o == 3'd2 || o == 3'd3) ? W + 2 : ML, model(o, x, y, h, l));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    a = '0; b = '0; hi_in = '0; lo_in = '0; last_res = '0;
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst ok", 64'(ok), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 0, "mult");
    do_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 0, "multu");
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0, "div");
    do_op(3'd3, 32'd100, 32'd7, 0, 0, 0, "divu");
    do_op(3'd3, 32'h1234, 32'd0, 0, 0, 0, "divu_b0");
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, "div_ovf");
    do_op(3'd2, 32'hFFFFFFF9, 32'd0, 0, 0, 0, "div_b0_neg");
    do_op(3'd5, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, "maddu");
    do_op(3'd6, 32'd1, 32'd1, 32'd0, 32'd0, 0, "msub");
    do_op(3'd4, 32'hFFFFFFFD, 32'd5, 32'h12345678, 32'h9ABCDEF0, 0, "madd");
    do_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h2, 0, "msubu");
    do_op(3'd0, 32'd1234, 32'd5678, 0, 0, 1, "noise_mul");
    do_op(3'd2, 32'hFFFF0000, 32'd13, 0, 0, 1, "noise_div");
    // flush an in-flight divide in cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd500; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'(last_res[63:32]));
    check("flush lo", 64'(lo), 64'(last_res[31:0]));
    repeat (40) begin
      check("flush no_ok", 64'(ok), 64'd0);
      @(negedge clk);
    end
    do_op(3'd3, 32'd99, 32'd10, 0, 0, 0, "after_flush");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush busy", 64'(busy), 64'd0);
    repeat (5) begin
      check("start_flush no_ok", 64'(ok), 64'd0);
      @(negedge clk);
    end
    check("start_flush hi", 64'(hi), 64'(last_res[63:32]));
    check("start_flush lo", 64'(lo), 64'(last_res[31:0]));
    // start held high: second op issues in the ok cycle of the first
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    op = 3'd1; a = 32'hDEADBEEF; b = 32'h1000;
    wait_ok("b2b1", 1, ML, model(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_ok("b2b2", 1, ML, model(3'd1, 32'hDEADBEEF, 32'h1000, 0, 0));
    repeat (30) begin
      r_op = 3'($urandom_range(0, 7));
      do_op(r_op, pick(), pick(), $urandom, $urandom, $urandom_range(0, 3) == 0, "rand");
    end
    do_op(3'd1, 32'd7, 32'd9, 0, 0, 0, "pre_rst");
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst ok", 64'(ok), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    repeat (40) begin
      check("midrst no_ok", 64'(ok), 64'd0);
      @(negedge clk);
    end
    do_op(3'd2, 32'd1000, 32'd7, 0, 0, 0, "post_rst");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
